// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM command-port arbiter: FSM encodings,
// default bus widths (shared with the SDRAM controller) and a width helper.
package sdram_port_arbiter_pkg;

  localparam int DEF_W_ADDR = 24;
  localparam int DEF_W_LEN  = 4;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE  = 2'd0;
  localparam arb_state_t ARB_ISSUE = 2'd1;
  localparam arb_state_t ARB_BUSY  = 2'd2;

  // $clog2 that never collapses to a zero-width index (single-entry selectors)
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_sel.sv
// Rotating-priority encoder: first set bit of req at or after start,
// wrapping past N-1 back to 0. Pure combinational.
module rr_priority_sel
  import sdram_port_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx
);

  logic          found;
  int            pos;
  logic [SW-1:0] pos_s;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    pos_s = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      pos_s = SW'(pos);
      if (!found && req[pos_s]) begin
        found      = 1'b1;
        gnt[pos_s] = 1'b1;
        idx        = pos_s;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller command port among N_PORTS masters with one
// transaction outstanding: port 0 fixed-high, others round-robin, starvation-bounded.
//
// state     | meaning
// ARB_IDLE  | arbitrate; on any request latch winner and command fields
// ARB_ISSUE | cmd_valid high, waiting for cmd_ready
// ARB_BUSY  | command accepted, waiting for cmd_done of the last beat
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int N_PORTS      = 3,
  parameter int W_ADDR       = DEF_W_ADDR,
  parameter int W_LEN        = DEF_W_LEN,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          req_valid,
  output logic [N_PORTS-1:0]          req_ready,
  input  logic [N_PORTS-1:0]          req_write,
  input  logic [N_PORTS*W_ADDR-1:0]   req_addr,
  input  logic [N_PORTS*W_LEN-1:0]    req_len,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic                        cmd_write,
  output logic [W_ADDR-1:0]           cmd_addr,
  output logic [W_LEN-1:0]            cmd_len,
  input  logic                        cmd_done,
  output logic                        grant_valid,
  output logic [$clog2(N_PORTS)-1:0]  grant_id
);

  localparam int IDW = $clog2(N_PORTS);
  localparam int NSW = clog2_min1(N_PORTS - 1);
  localparam int CW  = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0]  LIMIT     = CW'(STARVE_LIMIT);
  localparam logic [IDW-1:0] LAST_PORT = IDW'(N_PORTS - 1);
  localparam logic [IDW-1:0] FIRST_RR  = IDW'(1);

  arb_state_t        state_q, state_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic              cmd_write_q, cmd_write_d;
  logic [W_ADDR-1:0] cmd_addr_q, cmd_addr_d;
  logic [W_LEN-1:0]  cmd_len_q, cmd_len_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     wait_q [N_PORTS];
  logic [CW-1:0]     wait_d [N_PORTS];

  logic [N_PORTS-1:0] starved;
  logic [N_PORTS-1:0] starve_gnt;
  logic [IDW-1:0]     starve_idx;
  logic [N_PORTS-2:0] norm_gnt;
  logic [NSW-1:0]     norm_idx;
  logic [NSW-1:0]     norm_start;
  logic [IDW-1:0]     win_id;
  logic               take;

  assign cmd_valid   = (state_q == ARB_ISSUE);
  assign grant_valid = (state_q != ARB_IDLE);
  assign grant_id    = grant_id_q;
  assign cmd_write   = cmd_write_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_len     = cmd_len_q;
  assign take        = (state_q == ARB_IDLE) && (|req_valid);

  always_comb begin
    req_ready = '0;
    if (cmd_valid && cmd_ready) req_ready[grant_id_q] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      starved[i] = req_valid[i] && (wait_q[i] == LIMIT);
    end
  end

  // The normal selector only sees ports 1..N-1, so its pointer is rr_ptr-1.
  assign norm_start = NSW'(rr_ptr_q - FIRST_RR);

  rr_priority_sel #(.N(N_PORTS)) u_starve_sel (
    .req   (starved),
    .start (rr_ptr_q),
    .gnt   (starve_gnt),
    .idx   (starve_idx)
  );

  rr_priority_sel #(.N(N_PORTS - 1)) u_norm_sel (
    .req   (req_valid[N_PORTS-1:1]),
    .start (norm_start),
    .gnt   (norm_gnt),
    .idx   (norm_idx)
  );

  always_comb begin
    win_id = '0;
    if (|starve_gnt) begin
      win_id = starve_idx;
    end else if (!req_valid[0] && (|norm_gnt)) begin
      win_id = IDW'(norm_idx) + FIRST_RR;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (take) begin
          state_d     = ARB_ISSUE;
          grant_id_d  = win_id;
          cmd_write_d = req_write[win_id];
          cmd_addr_d  = req_addr[win_id*W_ADDR +: W_ADDR];
          cmd_len_d   = req_len[win_id*W_LEN +: W_LEN];
          if (win_id != '0) begin
            rr_ptr_d = (win_id == LAST_PORT) ? FIRST_RR : win_id + FIRST_RR;
          end
        end
      end
      ARB_ISSUE: begin
        if (cmd_ready) state_d = ARB_BUSY;
      end
      ARB_BUSY: begin
        if (cmd_done) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // The granted port does not age while its transaction is in flight.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      wait_d[i] = wait_q[i];
      if (take && (win_id == IDW'(i))) begin
        wait_d[i] = '0;
      end else if (req_valid[i] && !(grant_valid && (grant_id_q == IDW'(i))) &&
                   (wait_q[i] != LIMIT)) begin
        wait_d[i] = wait_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      grant_id_q  <= '0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      rr_ptr_q    <= FIRST_RR;
      for (int i = 0; i < N_PORTS; i++) wait_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      rr_ptr_q    <= rr_ptr_d;
      for (int i = 0; i < N_PORTS; i++) wait_q[i] <= wait_d[i];
    end
  end

endmodule
